// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REG_W_DEF = 5;

  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;
  localparam int unsigned LAT_MUL  = 3;
  localparam int unsigned LAT_DIV  = 7;

  localparam int unsigned RS_MAX_W  = 64;
  localparam int unsigned REG_MAX_W = 8;

  // Extract operand i (each w bits wide) from a packed source-index vector.
  function automatic logic [REG_MAX_W-1:0] rs_field(input logic [RS_MAX_W-1:0] rs,
                                                    input int unsigned i,
                                                    input int unsigned w);
    logic [RS_MAX_W-1:0] sh;
    logic [RS_MAX_W-1:0] mask;
    sh   = rs >> (i * w);
    mask = (RS_MAX_W'(1) << w) - RS_MAX_W'(1);
    return REG_MAX_W'(sh & mask);
  endfunction

endpackage

// File: rtl/reg_countdown.sv
// Loadable down-counter that stops at zero; nz flags a pending producer.
module reg_countdown #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             nz
);

  // Load has priority so a new issue overrides the running countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  assign nz = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard: stalls ID on RAW and WAW-ordering hazards.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = REG_W_DEF,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LAT_W    = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [REG_W-1:0]         id_rd,
  input  logic                     id_rd_we,
  input  logic [LAT_W-1:0]         id_lat,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_SRC-1:0]       stall_src,
  output logic                     waw_stall,
  output logic [NUM_REGS-1:0]      busy_mask,
  output logic [CNT_W-1:0]         stall_count
);

  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic             issue;

  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;

  // RAW check per source operand; x0 never hazards.
  always_comb begin : raw_detect
    logic [REG_W-1:0] idx;
    stall_src = '0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx          = REG_W'(rs_field(RS_MAX_W'(id_rs), i, REG_W));
      stall_src[i] = id_valid & id_rs_used[i] & (idx != '0) & (cnt[idx] != '0);
    end
  end

  // A younger write must not finish before an older in-flight one.
  assign waw_stall = id_valid & id_rd_we & (id_rd != '0) & (cnt[id_rd] > id_lat);

  assign stall = ~flush & ((|stall_src) | waw_stall);
  assign issue = id_valid & ~stall & ~flush;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    reg_countdown #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (issue & id_rd_we & (id_rd == REG_W'(r))),
      .load_val (id_lat),
      .cnt      (cnt[r]),
      .nz       (busy_mask[r])
    );
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_SRC  = 2;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned CNT_W    = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_rs;
  logic [NUM_SRC-1:0]       id_rs_used;
  logic [REG_W-1:0]         id_rd;
  logic                     id_rd_we;
  logic [LAT_W-1:0]         id_lat;
  logic                     flush;
  logic                     stall;
  logic [NUM_SRC-1:0]       stall_src;
  logic                     waw_stall;
  logic [NUM_REGS-1:0]      busy_mask;
  logic [CNT_W-1:0]         stall_count;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_W    (REG_W),
    .NUM_SRC  (NUM_SRC),
    .LAT_W    (LAT_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rd       (id_rd),
    .id_rd_we    (id_rd_we),
    .id_lat      (id_lat),
    .flush       (flush),
    .stall       (stall),
    .stall_src   (stall_src),
    .waw_stall   (waw_stall),
    .busy_mask   (busy_mask),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd, input logic we,
                       input logic [2:0] lat, input logic fl);
    id_valid   = v;
    id_rs      = {rs1, rs0};
    id_rs_used = used;
    id_rd      = rd;
    id_rd_we   = we;
    id_lat     = lat;
    flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0);
  endtask

  // Inputs are applied just after posedge; outputs are checked at negedge.
  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #3;
    to_next();
    rst_n = 1'b1;
    to_next();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();

    // Reset with random inputs applied.
    for (int k = 0; k < 4; k++) begin
      drive(1'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 5'($urandom),
            1'($urandom), 3'($urandom), 1'($urandom));
      to_negedge();
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_busy", 64'(busy_mask), 64'd0);
      check("rst_cnt", 64'(stall_count), 64'd0);
      to_next();
    end
    idle();
    rst_n = 1'b1;
    to_next();
    to_next();
    to_negedge();
    check("post_rst_busy", 64'(busy_mask), 64'd0);
    to_next();

    // Load-use: one bubble.
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd1, 1'b1, 3'd1, 1'b0);
    to_negedge();
    check("lu_prod_stall", 64'(stall), 64'd0);
    to_next();
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 3'd0, 1'b0);
    to_negedge();
    check("lu_stall", 64'(stall), 64'd1);
    check("lu_src", 64'(stall_src), 64'b01);
    check("lu_busy1", 64'(busy_mask[1]), 64'd1);
    to_next();
    to_negedge();
    check("lu_issue", 64'(stall), 64'd0);
    check("lu_count", 64'(stall_count), 64'd1);
    to_next();
    idle();
    to_negedge();
    check("lu_busy_after", 64'(busy_mask), 64'd0);
    to_next();

    // DIV chain: seven stall cycles on operand 1.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 3'd7, 1'b0);
    to_next();
    drive(1'b1, 5'd0, 5'd5, 2'b10, 5'd6, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      to_negedge();
      check("div_stall", 64'(stall), 64'd1);
      check("div_src", 64'(stall_src), 64'b10);
      check("div_busy5", 64'(busy_mask[5]), 64'd1);
      to_next();
    end
    to_negedge();
    check("div_release", 64'(stall), 64'd0);
    check("div_busy5_clr", 64'(busy_mask[5]), 64'd0);
    check("div_count", 64'(stall_count), 64'd7);
    to_next();

    // WAW: older lat=3, one idle cycle, then younger lat=0 waits two cycles.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 3'd3, 1'b0);
    to_next();
    idle();
    to_next();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      to_negedge();
      check("waw_stall", 64'(waw_stall), 64'd1);
      check("waw_src", 64'(stall_src), 64'd0);
      check("waw_stall_top", 64'(stall), 64'd1);
      to_next();
    end
    to_negedge();
    check("waw_release", 64'(stall), 64'd0);
    check("waw_count", 64'(stall_count), 64'd2);
    to_next();

    // WAW with equal remaining latency: no stall.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 3'd3, 1'b0);
    to_next();
    idle();
    to_next();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 3'd2, 1'b0);
    to_negedge();
    check("waw_eq_nostall", 64'(waw_stall), 64'd0);
    to_next();
    idle();
    to_negedge();
    check("waw_eq_reload", 64'(busy_mask[3]), 64'd1);
    to_next();

    // Flush masks stall but counters keep running.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 3'd3, 1'b0);
    to_next();
    drive(1'b1, 5'd4, 5'd0, 2'b01, 5'd8, 1'b1, 3'd5, 1'b1);
    for (int k = 0; k < 2; k++) begin
      to_negedge();
      check("fl_stall", 64'(stall), 64'd0);
      check("fl_src_unmasked", 64'(stall_src), 64'b01);
      to_next();
    end
    drive(1'b1, 5'd4, 5'd0, 2'b01, 5'd8, 1'b1, 3'd0, 1'b0);
    to_negedge();
    check("fl_resume_stall", 64'(stall), 64'd1);
    check("fl_no_issue", 64'(busy_mask[8]), 64'd0);
    to_next();
    to_negedge();
    check("fl_release", 64'(stall), 64'd0);
    check("fl_count", 64'(stall_count), 64'd1);
    to_next();

    // x0 producer is never tracked.
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 3'd7, 1'b0);
    to_next();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 3'd0, 1'b0);
    to_negedge();
    check("x0_busy", 64'(busy_mask), 64'd0);
    check("x0_stall", 64'(stall), 64'd0);
    to_next();

    // Both operands name the same busy register.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 3'd2, 1'b0);
    to_next();
    drive(1'b1, 5'd6, 5'd6, 2'b11, 5'd0, 1'b0, 3'd0, 1'b0);
    to_negedge();
    check("dual_src", 64'(stall_src), 64'b11);
    to_next();
    idle();
    to_negedge();
    check("idle_nostall", 64'(stall), 64'd0);
    check("idle_decrement", 64'(busy_mask[6]), 64'd1);
    to_next();
    to_negedge();
    check("idle_drained", 64'(busy_mask[6]), 64'd0);
    to_next();

    // Saturation: 21 stall cycles into a 4-bit counter.
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 3'd7, 1'b0);
      to_next();
      drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 3'd0, 1'b0);
      for (int k = 0; k < 7; k++) to_next();
      to_negedge();
      check("sat_chain_release", 64'(stall), 64'd0);
      to_next();
    end
    to_negedge();
    check("sat_hold", 64'(stall_count), 64'hF);
    to_next();

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 3'd7, 1'b0);
    to_next();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 3'd0, 1'b0);
    #1;
    check("mid_stall_pre", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_stall", 64'(stall), 64'd0);
    check("async_busy", 64'(busy_mask), 64'd0);
    check("async_count", 64'(stall_count), 64'd0);
    idle();
    to_next();
    rst_n = 1'b1;
    to_next();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
